// File: rtl/cube_move_scheduler_if.sv
// cube_move_scheduler_if
//  Bundles the PMOD input lines, the software START/DONE/clear handshake and
//  the scheduler status outputs into one port.
//  slave  : the scheduler (takes pmod_in/cpu_start/cpu_done/clr_flags,
//           drives move_valid/move_code/fifo_count/busy and the sticky flags)
//  master : the side that drives the pins and software handshake
interface cube_move_scheduler_if #(
  parameter int FIFO_DEPTH = 8
) ();
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [4:0]    pmod_in;
  logic          cpu_start;
  logic          cpu_done;
  logic          clr_flags;
  logic          move_valid;
  logic [3:0]    move_code;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          overflow;
  logic          illegal_code;
  logic          timeout;

  modport master (
    output pmod_in, cpu_start, cpu_done, clr_flags,
    input  move_valid, move_code, fifo_count, busy, overflow, illegal_code, timeout
  );

  modport slave (
    input  pmod_in, cpu_start, cpu_done, clr_flags,
    output move_valid, move_code, fifo_count, busy, overflow, illegal_code, timeout
  );
endinterface

// File: rtl/cube_move_scheduler.sv
// cube_move_scheduler
//  Takes cube turn commands from the WiFi module's 5-bit PMOD bus, synchronises
//  and debounces them, drops illegal codes, queues legal moves and hands them to
//  software one at a time over a START/DONE level handshake with a timeout.
//  Ports:
//   HCLK    system clock
//   HRESET  asynchronous active-high reset
//   bus     cube_move_scheduler_if.slave (pmod_in, cpu_start, cpu_done,
//           clr_flags in; move_valid, move_code, fifo_count, busy, overflow,
//           illegal_code, timeout out)
module cube_move_scheduler #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2 ** 20
) (
  input logic                    HCLK,
  input logic                    HRESET,
  cube_move_scheduler_if.slave   bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_MAX   = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RETIRE} state_t;

  // ---------------- synchroniser chain ----------------
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : sync_stage
      logic [4:0] stage_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge HCLK or posedge HRESET) begin
          if (HRESET) stage_reg <= '0;
          else        stage_reg <= bus.pmod_in;
        end
      end else begin : g_next
        always_ff @(posedge HCLK or posedge HRESET) begin
          if (HRESET) stage_reg <= '0;
          else        stage_reg <= sync_stage[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  logic [4:0] synced;
  assign synced = sync_stage[SYNC_STAGES-1].stage_reg;

  // ---------------- debounce ----------------
  logic          strobe_last_reg;
  logic [SW-1:0] stable_cnt_reg;
  logic          filt_reg;
  logic          stable_take;
  logic          capture;
  logic          code_legal;

  // The counter restarts the cycle after any change of the synced strobe and
  // saturates; once saturated the synced level is trusted.
  assign stable_take = (synced[4] == strobe_last_reg) && (stable_cnt_reg == STABLE_MAX);
  assign capture     = stable_take && synced[4] && !filt_reg;
  assign code_legal  = synced[3:0] < 4'd12;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      strobe_last_reg <= 1'b0;
      stable_cnt_reg  <= '0;
      filt_reg        <= 1'b0;
    end else begin
      strobe_last_reg <= synced[4];
      if (synced[4] != strobe_last_reg)
        stable_cnt_reg <= '0;
      else if (stable_cnt_reg != STABLE_MAX)
        stable_cnt_reg <= stable_cnt_reg + 1'b1;
      if (stable_take)
        filt_reg <= synced[4];
    end
  end

  // ---------------- move FIFO ----------------
  logic [3:0]    mem_reg [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [3:0]    head;
  logic          fifo_full;
  logic          push_req;
  logic          push;
  logic          pop;
  state_t        state_reg;

  assign head      = mem_reg[rd_ptr_reg];
  assign fifo_full = (count_reg == FULL_COUNT);
  assign push_req  = capture && code_legal;
  assign pop       = (state_reg == IDLE) && bus.cpu_start && (count_reg != '0) && !bus.cpu_done;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push      = push_req && (!fifo_full || pop);

  always_ff @(posedge HCLK) begin
    if (push) mem_reg[wr_ptr_reg] <= synced[3:0];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // ---------------- issue FSM ----------------
  logic          move_valid_reg;
  logic [3:0]    move_code_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic          timeout_reg;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg      <= IDLE;
      move_valid_reg <= 1'b0;
      move_code_reg  <= 4'd0;
      tmo_cnt_reg    <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      if (bus.clr_flags) timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            move_valid_reg <= 1'b1;
            move_code_reg  <= head;
            tmo_cnt_reg    <= '0;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.cpu_done) begin
            move_valid_reg <= 1'b0;
            state_reg      <= RETIRE;
          end else if (tmo_cnt_reg == TIMEOUT_LAST) begin
            // Placed after the clear so a coincident timeout wins.
            timeout_reg    <= 1'b1;
            move_valid_reg <= 1'b0;
            state_reg      <= RETIRE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        RETIRE: begin
          // Wait for software to drop DONE so one DONE level retires one move.
          if (!bus.cpu_done) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // ---------------- sticky flags ----------------
  logic overflow_reg;
  logic illegal_reg;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      overflow_reg <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      overflow_reg <= (overflow_reg && !bus.clr_flags) || (push_req && fifo_full && !pop);
      illegal_reg  <= (illegal_reg && !bus.clr_flags) || (capture && !code_legal);
    end
  end

  assign bus.move_valid   = move_valid_reg;
  assign bus.move_code    = move_code_reg;
  assign bus.fifo_count   = count_reg;
  assign bus.busy         = move_valid_reg || (count_reg != '0);
  assign bus.overflow     = overflow_reg;
  assign bus.illegal_code = illegal_reg;
  assign bus.timeout      = timeout_reg;
endmodule
